// File: rtl/pdpu_pkg.sv
// Shared types and helpers for the posit dot-product datapath.
// Widths here are the defaults that exp_align_stage exposes as parameters.
package pdpu_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MANT_W  = 14;
    localparam int unsigned ALIGN_W = 24;

    typedef logic signed [EXP_W:0] exp_t;

    localparam exp_t EXP_MIN = {1'b1, {EXP_W{1'b0}}};

    typedef struct packed {
        logic               sign;
        logic [ALIGN_W-1:0] mant;
        logic               sticky;
    } align_term_t;

    // Two's-complement max: a negative operand always loses to a non-negative one;
    // same-sign operands order correctly on their low bits as unsigned values.
    function automatic exp_t exp_max(input exp_t a, input exp_t b);
        if (a[EXP_W] != b[EXP_W]) begin
            return a[EXP_W] ? b : a;
        end
        return (a[EXP_W-1:0] >= b[EXP_W-1:0]) ? a : b;
    endfunction

endpackage

// File: rtl/exp_align_stage_align_lane.sv
// One alignment lane: shift amount, saturating right shift of the mantissa frame,
// and (when PDPU_ALIGN_STICKY_EN is defined) the sticky OR of the bits shifted out.
module align_lane
    import pdpu_pkg::*;
(
    input  exp_t                emax_i,
    input  exp_t                exp_i,
    input  logic [MANT_W-1:0]   mant_i,
    input  logic                sign_i,
    input  logic                zero_i,
    output align_term_t         term_o
);

    localparam int unsigned     SH_W   = EXP_W + 2;
    localparam logic [SH_W-1:0] SH_SAT = SH_W'(ALIGN_W);

    logic [SH_W-1:0]    sh;
    logic [ALIGN_W-1:0] frame;
    logic               saturate;

    // Sign-extend both exponents by one bit so the difference cannot overflow.
    assign sh       = {emax_i[EXP_W], emax_i} - {exp_i[EXP_W], exp_i};
    assign frame    = ALIGN_W'(mant_i) << (ALIGN_W - MANT_W);
    assign saturate = (sh >= SH_SAT);

    always_comb begin
        term_o.sign   = sign_i;
        term_o.mant   = '0;
        term_o.sticky = 1'b0;
        if (!zero_i && !saturate) begin
            term_o.mant = frame >> sh;
        end
`ifdef PDPU_ALIGN_STICKY_EN
        if (!zero_i) begin
            term_o.sticky = saturate ? (|mant_i) : (|(frame & ~({ALIGN_W{1'b1}} << sh)));
        end
`endif
    end

endmodule

// File: rtl/exp_align_stage.sv
// Two-stage exponent-alignment stage: S1 registers the max exponent and raw terms,
// S2 registers the aligned terms. Sticky output is enabled by PDPU_ALIGN_STICKY_EN.
module exp_align_stage #(
    parameter int unsigned N       = 4,
    parameter int unsigned EXP_W   = pdpu_pkg::EXP_W,
    parameter int unsigned MANT_W  = pdpu_pkg::MANT_W,
    parameter int unsigned ALIGN_W = pdpu_pkg::ALIGN_W
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [N-1:0][EXP_W:0]         exp_i,
    input  logic [N-1:0][MANT_W-1:0]      mant_i,
    input  logic [N-1:0]                  sign_i,
    input  logic [N-1:0]                  zero_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [EXP_W:0]                exp_max_o,
    output logic [N-1:0][ALIGN_W-1:0]     mant_o,
    output logic [N-1:0]                  sign_o,
    output logic [N-1:0]                  sticky_o
);

    import pdpu_pkg::*;

    logic in_fire;
    logic s1_fire;
    logic s2_ready;

    logic                      s1_valid;
    exp_t                      s1_emax;
    logic [N-1:0][EXP_W:0]     s1_exp;
    logic [N-1:0][MANT_W-1:0]  s1_mant;
    logic [N-1:0]              s1_sign;
    logic [N-1:0]              s1_zero;

    logic                      s2_valid;
    exp_t                      s2_emax;
    logic [N-1:0][ALIGN_W-1:0] s2_mant;
    logic [N-1:0]              s2_sign;
    logic [N-1:0]              s2_sticky;

    exp_t        lvl [N];
    exp_t        emax_in;
    align_term_t lane_term [N];

    assign s2_ready   = !s2_valid || out_ready_i;
    assign in_ready_o = !s1_valid || s2_ready;
    assign in_fire    = in_valid_i && in_ready_o;
    assign s1_fire    = s1_valid && s2_ready;

    // Pairwise reduction in place: each level halves the live width, log2(N) levels.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            lvl[i] = zero_i[i] ? EXP_MIN : exp_t'(exp_i[i]);
        end
        for (int unsigned w = N / 2; w > 0; w = w / 2) begin
            for (int unsigned i = 0; i < w; i++) begin
                lvl[i] = exp_max(lvl[2*i], lvl[2*i+1]);
            end
        end
        emax_in = lvl[0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_emax  <= '0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_sign  <= '0;
            s1_zero  <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s1_fire) begin
                s1_valid <= 1'b0;
            end
            if (in_fire) begin
                s1_emax <= emax_in;
                s1_exp  <= exp_i;
                s1_mant <= mant_i;
                s1_sign <= sign_i;
                s1_zero <= zero_i;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        align_lane u_align_lane (
            .emax_i (s1_emax),
            .exp_i  (s1_exp[i]),
            .mant_i (s1_mant[i]),
            .sign_i (s1_sign[i]),
            .zero_i (s1_zero[i]),
            .term_o (lane_term[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid  <= 1'b0;
            s2_emax   <= '0;
            s2_mant   <= '0;
            s2_sign   <= '0;
            s2_sticky <= '0;
        end else begin
            if (s1_fire) begin
                s2_valid <= 1'b1;
            end else if (out_ready_i) begin
                s2_valid <= 1'b0;
            end
            if (s1_fire) begin
                s2_emax <= s1_emax;
                for (int unsigned i = 0; i < N; i++) begin
                    s2_mant[i]   <= lane_term[i].mant;
                    s2_sign[i]   <= lane_term[i].sign;
                    s2_sticky[i] <= lane_term[i].sticky;
                end
            end
        end
    end

    assign out_valid_o = s2_valid;
    assign exp_max_o   = s2_emax;
    assign mant_o      = s2_mant;
    assign sign_o      = s2_sign;
    assign sticky_o    = s2_sticky;

endmodule

// File: tb/tb_exp_align_stage.sv
// Directed self-checking bench for exp_align_stage (N=4, EXP_W=8, MANT_W=14, ALIGN_W=24).
module tb_exp_align_stage;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [3:0][8:0]  exp_i = '0;
    logic [3:0][13:0] mant_i = '0;
    logic [3:0]       sign_i = '0;
    logic [3:0]       zero_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [8:0]       exp_max_o;
    logic [3:0][23:0] mant_o;
    logic [3:0]       sign_o;
    logic [3:0]       sticky_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exp_align_stage #(
        .N       (4),
        .EXP_W   (8),
        .MANT_W  (14),
        .ALIGN_W (24)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .exp_i       (exp_i),
        .mant_i      (mant_i),
        .sign_i      (sign_i),
        .zero_i      (zero_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .exp_max_o   (exp_max_o),
        .mant_o      (mant_o),
        .sign_o      (sign_o),
        .sticky_o    (sticky_o)
    );

    // Drives one beat into an idle pipeline and reports how many edges until out_valid_o.
    task automatic send_beat(input int e0, input int e1, input int e2, input int e3,
                             input logic [13:0] m, input logic [3:0] z, input logic [3:0] s,
                             output int lat);
        @(negedge clk);
        exp_i[0] = 9'(e0);
        exp_i[1] = 9'(e1);
        exp_i[2] = 9'(e2);
        exp_i[3] = 9'(e3);
        for (int j = 0; j < 4; j++) mant_i[j] = m;
        zero_i      = z;
        sign_i      = s;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid_o);
        end
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready_o);
        end
        n_checks++;
        if (exp_max_o !== 9'h000 || mant_o !== '0 || sign_o !== 4'h0 || sticky_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: got exp %h mant %h sign %b sticky %b expected all zero",
                     exp_max_o, mant_o, sign_o, sticky_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        logic [23:0] em [4];
        em = '{24'h200000, 24'h010000, 24'h800000, 24'h040000};
        send_beat(3, -2, 5, 0, 14'h2000, 4'b0000, 4'b1010, lat);
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 2", lat);
        end
        n_checks++;
        if (exp_max_o !== 9'd5) begin
            n_fail++;
            $display("FAIL basic_emax: got %h expected %h", exp_max_o, 9'd5);
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (mant_o[j] !== em[j]) begin
                n_fail++;
                $display("FAIL basic_mant%0d: got %h expected %h", j, mant_o[j], em[j]);
            end
        end
        n_checks++;
        if (sign_o !== 4'b1010 || sticky_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL basic_sign_sticky: got sign %b sticky %b expected 1010 0000", sign_o, sticky_o);
        end
    endtask

    task automatic test_negative();
        int lat;
        logic [23:0] em [4];
        logic [3:0]  es;
        em = '{24'h800000, 24'h010000, 24'h200000, 24'h000000};
`ifdef PDPU_ALIGN_STICKY_EN
        es = 4'b1000;
`else
        es = 4'b0000;
`endif
        send_beat(-1, -8, -3, -128, 14'h2000, 4'b0000, 4'b0000, lat);
        n_checks++;
        if (exp_max_o !== 9'h1FF) begin
            n_fail++;
            $display("FAIL neg_emax: got %h expected %h", exp_max_o, 9'h1FF);
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (mant_o[j] !== em[j]) begin
                n_fail++;
                $display("FAIL neg_mant%0d: got %h expected %h", j, mant_o[j], em[j]);
            end
        end
        n_checks++;
        if (sticky_o !== es) begin
            n_fail++;
            $display("FAIL neg_sticky: got %b expected %b", sticky_o, es);
        end
    endtask

    task automatic test_all_zero();
        int lat;
        send_beat(7, 3, -5, 100, 14'h3FFF, 4'b1111, 4'b0110, lat);
        n_checks++;
        if (exp_max_o !== 9'h100) begin
            n_fail++;
            $display("FAIL zero_emax: got %h expected %h", exp_max_o, 9'h100);
        end
        n_checks++;
        if (mant_o !== '0 || sticky_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL zero_mant_sticky: got mant %h sticky %b expected 0 0000", mant_o, sticky_o);
        end
        n_checks++;
        if (sign_o !== 4'b0110) begin
            n_fail++;
            $display("FAIL zero_sign: got %b expected 0110", sign_o);
        end
    endtask

    task automatic test_saturate();
        int lat;
        logic [23:0] em [4];
        logic [3:0]  es;
        em = '{24'hFFFC00, 24'h000000, 24'h00000F, 24'h00000F};
`ifdef PDPU_ALIGN_STICKY_EN
        es = 4'b1110;
`else
        es = 4'b0000;
`endif
        send_beat(20, -20, 0, 0, 14'h3FFF, 4'b0000, 4'b0000, lat);
        n_checks++;
        if (exp_max_o !== 9'd20) begin
            n_fail++;
            $display("FAIL sat_emax: got %h expected %h", exp_max_o, 9'd20);
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (mant_o[j] !== em[j]) begin
                n_fail++;
                $display("FAIL sat_mant%0d: got %h expected %h", j, mant_o[j], em[j]);
            end
        end
        n_checks++;
        if (sticky_o !== es) begin
            n_fail++;
            $display("FAIL sat_sticky: got %b expected %b", sticky_o, es);
        end
    endtask

    task automatic test_shift_boundary();
        int lat;
        logic [23:0] em [4];
        logic [3:0]  es;
        em = '{24'h800000, 24'h000001, 24'h000000, 24'h800000};
`ifdef PDPU_ALIGN_STICKY_EN
        es = 4'b0100;
`else
        es = 4'b0000;
`endif
        send_beat(24, 1, 0, 24, 14'h2000, 4'b0000, 4'b0000, lat);
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (mant_o[j] !== em[j]) begin
                n_fail++;
                $display("FAIL bound_mant%0d: got %h expected %h", j, mant_o[j], em[j]);
            end
        end
        n_checks++;
        if (sticky_o !== es) begin
            n_fail++;
            $display("FAIL bound_sticky: got %b expected %b", sticky_o, es);
        end
    endtask

    task automatic test_zero_mix();
        int lat;
        logic [23:0] em [4];
        em = '{24'h800000, 24'h000000, 24'h008000, 24'h020000};
        send_beat(10, 100, 2, 4, 14'h2000, 4'b0010, 4'b0000, lat);
        n_checks++;
        if (exp_max_o !== 9'd10) begin
            n_fail++;
            $display("FAIL mix_emax: got %h expected %h", exp_max_o, 9'd10);
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (mant_o[j] !== em[j]) begin
                n_fail++;
                $display("FAIL mix_mant%0d: got %h expected %h", j, mant_o[j], em[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] got [$];
        logic [23:0] held;
        logic [23:0] exp_v;
        int sent = 0;
        int cyc  = 0;
        exp_i  = '0;
        zero_i = '0;
        sign_i = '0;
        held   = '0;
        while (got.size() < 6 && cyc < 40) begin
            @(negedge clk);
            out_ready_i = !(cyc >= 2 && cyc <= 4);
            in_valid_i  = (sent < 6);
            for (int j = 0; j < 4; j++) mant_i[j] = 14'h2000 + 14'(sent);
            #1;
            if (cyc == 2) begin
                n_checks++;
                if (in_ready_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_in_ready_drop: got %b expected 0", in_ready_o);
                end
                n_checks++;
                if (out_valid_o !== 1'b1 || mant_o[0] !== 24'h800000) begin
                    n_fail++;
                    $display("FAIL stream_first_out: got valid %b mant %h expected 1 800000",
                             out_valid_o, mant_o[0]);
                end
                held = mant_o[0];
            end
            if (cyc == 3 || cyc == 4) begin
                n_checks++;
                if (out_valid_o !== 1'b1 || mant_o[0] !== held) begin
                    n_fail++;
                    $display("FAIL stream_hold_c%0d: got valid %b mant %h expected 1 %h",
                             cyc, out_valid_o, mant_o[0], held);
                end
            end
            if (out_valid_o && out_ready_i) got.push_back(mant_o[0]);
            if (in_valid_i && in_ready_o) sent++;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        n_checks++;
        if (got.size() != 6) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected 6", got.size());
        end
        for (int k = 0; k < got.size() && k < 6; k++) begin
            exp_v = 24'(14'h2000 + 14'(k)) << 10;
            n_checks++;
            if (got[k] !== exp_v) begin
                n_fail++;
                $display("FAIL stream_beat%0d: got %h expected %h", k, got[k], exp_v);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        @(negedge clk);
        out_ready_i = 1'b0;
        exp_i       = '{9'd1, 9'd2, 9'd3, 9'd7};
        for (int j = 0; j < 4; j++) mant_i[j] = 14'h3000;
        zero_i     = '0;
        sign_i     = 4'b1111;
        in_valid_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b1 || exp_max_o !== 9'd7) begin
            n_fail++;
            $display("FAIL flight_loaded: got valid %b emax %h expected 1 %h", out_valid_o, exp_max_o, 9'd7);
        end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flight_reset_valid: got valid %b ready %b expected 0 1", out_valid_o, in_ready_o);
        end
        n_checks++;
        if (exp_max_o !== 9'h000 || mant_o !== '0 || sign_o !== 4'h0) begin
            n_fail++;
            $display("FAIL flight_reset_data: got emax %h mant %h sign %b expected zeros",
                     exp_max_o, mant_o, sign_o);
        end
        @(negedge clk);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL flight_stale_c%0d: got valid %b expected 0", c, out_valid_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_all_zero();
        test_saturate();
        test_shift_boundary();
        test_zero_mix();
        test_back_to_back();
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
